sc_mul_seq_ctrl: RTL
====================

Name: sc_mul_seq_ctrl

Overview:
- Sequencer for one stochastic-computing multiply pass.
- Clears and then enables the Sobol RNG pair and its enable counter for a programmable stream length.
- Counts the ones in the returned product bitstream and returns the unipolar count and bipolar value through a valid/ready handshake.
- Sits between the host/accumulator logic and the sobolrng plus uMUL datapath.

Parameters:
- BITWIDTH, 8, RNG and operand width. Maximum stream length is 2^BITWIDTH.

Ports:
- iClk  in  1  clock.
- iRstN  in  1  asynchronous reset, active low.
- iStart  in  1  request a pass; accepted only when oReady=1.
- oReady  out  1  controller idle and able to accept iStart.
- iLen  in  BITWIDTH+1  stream length, captured on accept; 0 means 2^BITWIDTH.
- iAbort  in  1  synchronous abort of the current pass.
- oRngClr  out  1  drives iClr of the sobolrng instances.
- oRngEn  out  1  drives iEn of the sobolrng instances.
- iBit  in  1  product bit from the uMUL; sampled on every cycle with oRngEn=1.
- oValid  out  1  result available.
- iReady  in  1  consumer accepts the result.
- oOnes  out  BITWIDTH+1  count of ones in the stream.
- oBipolar  out  BITWIDTH+2  signed value, 2*oOnes - L.

Behaviour:
- Clock and reset: one clock, iClk. Reset is asynchronous and active-low on iRstN.
- Values during reset: state=IDLE, oReady=1, oRngEn=0, oRngClr=0, oValid=0, oOnes=0, oBipolar=0, internal counters=0.
- State IDLE:
  - oReady=1.
  - iStart=1 captures L: iLen, or 2^BITWIDTH when iLen=0.
  - Next state is CLEAR.
- State CLEAR (exactly 1 cycle):
  - oRngClr=1, oRngEn=0.
  - Cycle counter and ones counter are zeroed.
  - Next state is RUN.
- State RUN (exactly L cycles):
  - oRngEn=1.
  - Ones counter += iBit each cycle.
  - Cycle counter increments; when it equals L-1, the last bit is sampled and the next state is DONE.
- State DONE:
  - oValid=1; oOnes and oBipolar are registered and stable.
  - iReady=1 moves to IDLE, and oValid drops the next cycle.
  - Result is held indefinitely while iReady=0.
- Timing: if iStart is accepted at edge T, oRngClr is high in cycle T+1, oRngEn is high in cycles T+2..T+1+L, and oValid rises at T+2+L. Start-to-valid latency is L+2 cycles.
- Arithmetic:
  - oOnes is at most 2^BITWIDTH, so BITWIDTH+1 bits never overflow.
  - oBipolar is computed in BITWIDTH+2-bit two's complement and ranges from -2^BITWIDTH to +2^BITWIDTH.
- oReady is 0 in CLEAR, RUN and DONE. iStart in those states is ignored and not queued.
- iStart and iReady in the same DONE cycle: the start is ignored and is accepted only once IDLE is reached (1-cycle bubble).
- iAbort=1 in CLEAR, RUN or DONE:
  - Next state is IDLE, oValid=0, oRngEn=0.
  - The result is discarded.
  - iAbort has priority over all other inputs. In IDLE it has no effect and also blocks a same-cycle iStart.
- Reset asserted mid-pass: immediate return to reset values. No partial result is ever presented.
- iLen changes after accept have no effect.
- oRngEn and oRngClr are never both 1.

Decomposition:
- Shared package (sc_pkg): state encoding constants (IDLE, CLEAR, RUN, DONE, 2-bit).
- Sub-module: cntwithen with BITWIDTH+1, instantiated twice.
  - Cycle counter: iEn=oRngEn, iClr=oRngClr.
  - Ones counter: iEn=oRngEn&iBit, iClr=oRngClr.
- FSM, length capture and bipolar arithmetic live in sc_mul_seq_ctrl.

Test Plan:
1. BITWIDTH=8, iLen=4, iBit=1 throughout RUN -> oRngEn high exactly 4 cycles; oValid at start+6 with oOnes=4, oBipolar=+4.
2. iLen=0 (L=256), iBit alternating 1/0 -> 256 enable cycles; oOnes=128, oBipolar=0.
3. iLen=1, iBit=0 -> oOnes=0, oBipolar=-1. Then hold iReady=0 for 5 cycles while pulsing iStart -> result stable, oReady=0, no new pass starts.
4. iStart and iReady asserted together in DONE -> return to IDLE, start ignored. iStart the next cycle is accepted, with oRngClr pulsing 1 cycle later.
5. iAbort in RUN cycle 3 of L=10 -> next cycle IDLE, oRngEn=0, oValid never asserted. A following pass with iLen=2 and iBit=1 gives oOnes=2 (counters cleared).
6. iRstN low mid-RUN -> all outputs at reset values immediately. After release, oReady=1 and a new pass completes normally.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing multiply sequencer.
package sc_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cntwithen.sv
// Up-counter with synchronous clear (priority) and count enable.
module cntwithen #(
  parameter int WIDTH = 9
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iEn,
  input  logic             iClr,
  output logic [WIDTH-1:0] oCnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (iClr)
      cnt_d = '0;
    else if (iEn)
      cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign oCnt = cnt_q;

endmodule

// File: rtl/sc_mul_seq_ctrl.sv
// Sequencer for one stochastic-computing multiply pass: clears/enables the RNGs,
// counts product ones and returns unipolar count and bipolar value via valid/ready.
module sc_mul_seq_ctrl
  import sc_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic                       iClk,
  input  logic                       iRstN,
  input  logic                       iStart,
  output logic                       oReady,
  input  logic [BITWIDTH:0]          iLen,
  input  logic                       iAbort,
  output logic                       oRngClr,
  output logic                       oRngEn,
  input  logic                       iBit,
  output logic                       oValid,
  input  logic                       iReady,
  output logic [BITWIDTH:0]          oOnes,
  output logic signed [BITWIDTH+1:0] oBipolar
);

  localparam int CW = BITWIDTH + 1;
  localparam int BW = BITWIDTH + 2;

  state_e               state_q, state_d;
  logic [CW-1:0]        len_q, len_d;
  logic signed [BW-1:0] bip_q, bip_d;
  logic [CW-1:0]        cyc_cnt;
  logic [CW-1:0]        ones_cnt;
  logic                 last_run;

  // 2*ones - L in two's complement; the doubled term may wrap but the difference is exact.
  function automatic logic signed [BW-1:0] to_bipolar(input logic [CW-1:0] ones,
                                                     input logic [CW-1:0] len);
    return $signed({ones, 1'b0}) - $signed({1'b0, len});
  endfunction

  cntwithen #(.WIDTH(CW)) u_cyc_cnt (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (oRngEn),
    .iClr  (oRngClr),
    .oCnt  (cyc_cnt)
  );

  cntwithen #(.WIDTH(CW)) u_ones_cnt (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (oRngEn & iBit),
    .iClr  (oRngClr),
    .oCnt  (ones_cnt)
  );

  assign last_run = (state_q == RUN) && (cyc_cnt == len_q - CW'(1));

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      len_q   <= '0;
      bip_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bip_q   <= bip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bip_d   = bip_q;
    case (state_q)
      IDLE: begin
        // Abort also suppresses a same-cycle start.
        if (iStart && !iAbort) begin
          state_d = CLEAR;
          len_d   = (iLen == '0) ? CW'(1 << BITWIDTH) : iLen;
        end
      end
      CLEAR: state_d = iAbort ? IDLE : RUN;
      RUN: begin
        if (iAbort)
          state_d = IDLE;
        else if (last_run) begin
          state_d = DONE;
          bip_d   = to_bipolar(ones_cnt + CW'(iBit), len_q);
        end
      end
      DONE: begin
        if (iAbort || iReady)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Results are exposed only while valid so an aborted pass never leaks a partial count.
  always_comb begin
    oReady   = (state_q == IDLE);
    oRngClr  = (state_q == CLEAR);
    oRngEn   = (state_q == RUN);
    oValid   = (state_q == DONE);
    oOnes    = oValid ? ones_cnt : '0;
    oBipolar = oValid ? bip_q : '0;
  end

endmodule
